pipeline_sequencer: RTL and testbench

Central stall/flush controller for the 5-stage 16-bit pipelined CPU. It combines the ID-stage data-hazard stall, branch/jump redirects, Harvard memory wait handshakes and HLT draining into per-stage latch enables and flushes. It also keeps retired-instruction and stall-cycle counters. It sits beside the hazard detector and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/seq_pkg.sv | 5 +
 rtl/perf_counters.sv | 30 +++
 rtl/pipeline_sequencer.sv | 98 +++++++++
 tb/tb_pipeline_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: sequencer state encodings and counter width default shared by the stall/flush controller.
package seq_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/perf_counters.sv
// perf_counters: retired-instruction counter (wrapping) and stall-cycle counter (saturating).
module perf_counters
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_inst,
  input  logic             inc_stall,
  output logic [CNT_W-1:0] num_inst,
  output logic [CNT_W-1:0] stall_cycles
);
  logic [CNT_W-1:0] num_inst_q, num_inst_d, stall_cycles_q, stall_cycles_d;
  always_comb begin
    num_inst_d     = inc_inst ? num_inst_q + CNT_W'(1) : num_inst_q;
    stall_cycles_d = (inc_stall && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_inst_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      num_inst_q     <= num_inst_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign num_inst     = num_inst_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: priority-ordered stall/flush control of the 5-stage pipeline plus HLT drain FSM.
module pipeline_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hz_stall,
  input  logic             id_valid,
  input  logic             id_redirect,
  input  logic             id_halt,
  input  logic             ex_redirect,
  input  logic             i_req,
  input  logic             i_ready,
  input  logic             d_req,
  input  logic             d_ready,
  input  logic             wb_valid,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] num_inst,
  output logic [CNT_W-1:0] stall_cycles
);
  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   dwait, iwait, inc_stall, inc_inst;
  always_comb begin
    dwait        = d_req & ~d_ready;
    iwait        = i_req & ~i_ready;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    inc_stall    = 1'b0;
    if (!reset_n) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush} = '1;
    end else if (state_q == HALTED) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
    end else if (dwait) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hz_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      inc_stall   = 1'b1;
    end else if (state_q == DRAIN) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end else if (id_redirect) begin
      if_id_flush = 1'b1;
    end else if (iwait) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
    // A redirect stalled behind a data wait must not cancel the drain until it actually resolves.
    state_d = state_q;
    if (state_q == RUN && id_halt && id_valid && !hz_stall && !ex_redirect && !dwait) state_d = DRAIN;
    else if (state_q == DRAIN && wb_valid && wb_halt) state_d = HALTED;
    else if (state_q == DRAIN && ex_redirect && !dwait) state_d = RUN;
    halted_d = (state_d == HALTED);
    inc_inst = wb_valid && (state_q != HALTED);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end
  assign halted = halted_q;
  perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc_inst    (inc_inst),
    .inc_stall   (inc_stall),
    .num_inst    (num_inst),
    .stall_cycles(stall_cycles)
  );
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: table-driven stage-control vectors through a scoreboard queue, plus drain/counter sequences.
module tb_pipeline_sequencer;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0, hz_stall = 1'b0, id_valid = 1'b0, id_redirect = 1'b0, id_halt = 1'b0;
  logic ex_redirect = 1'b0, i_req = 1'b0, i_ready = 1'b0, d_req = 1'b0, d_ready = 1'b0;
  logic wb_valid = 1'b0, wb_halt = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_write, mem_wb_flush, halted;
  logic [CW-1:0] num_inst, stall_cycles;
  logic [7:0] ctrl;
  int n_checks = 0, n_fail = 0, step = 0;

  pipeline_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .hz_stall(hz_stall), .id_valid(id_valid),
    .id_redirect(id_redirect), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .i_req(i_req), .i_ready(i_ready), .d_req(d_req), .d_ready(d_ready),
    .wb_valid(wb_valid), .wb_halt(wb_halt), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .num_inst(num_inst),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                 ex_mem_write, mem_wb_write, mem_wb_flush};

  localparam logic [11:0] I_R = 12'h800, I_HZ = 12'h400, I_IV = 12'h200, I_IDR = 12'h100;
  localparam logic [11:0] I_IH = 12'h080, I_EXR = 12'h040, I_IQ = 12'h020, I_IY = 12'h010;
  localparam logic [11:0] I_DQ = 12'h008, I_DY = 12'h004, I_WV = 12'h002, I_WH = 12'h001;
  // ctrl order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, memwb_f
  localparam logic [7:0] C_NORM = 8'b1101_0110, C_RST = 8'b0010_1001, C_HLT = 8'b0000_0000;
  localparam logic [7:0] C_DW = 8'b0000_0011, C_EXR = 8'b1111_1110, C_HZ = 8'b0001_1110;
  localparam logic [7:0] C_DRN = 8'b0111_0110, C_IDR = 8'b1111_0110, C_IW = 8'b0111_0110;

  typedef struct { logic [11:0] in; logic [7:0] ctrl; } vec_t;
  typedef struct { logic [7:0] ctrl; int step; } exp_t;
  exp_t exp_q[$];
  vec_t tbl[15];

  task automatic apply(input logic [11:0] v, input logic [7:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    {reset_n, hz_stall, id_valid, id_redirect, id_halt, ex_redirect,
     i_req, i_ready, d_req, d_ready, wb_valid, wb_halt} = v;
    step++;
    exp_q.push_back('{ctrl: e, step: step});
    @(negedge clk);
    x = exp_q.pop_front();
    n_checks++;
    if (ctrl !== x.ctrl) begin
      n_fail++;
      $display("FAIL ctrl step %0d: got %b, required %b", x.step, ctrl, x.ctrl);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d, required %0d", nm, step, act, req);
    end
  endtask

  initial begin
    tbl[0]  = '{I_R, C_NORM};
    tbl[1]  = '{I_R | I_HZ, C_HZ};
    tbl[2]  = '{I_R | I_EXR, C_EXR};
    tbl[3]  = '{I_R | I_EXR | I_HZ, C_EXR};
    tbl[4]  = '{I_R | I_DQ, C_DW};
    tbl[5]  = '{I_R | I_DQ | I_DY, C_NORM};
    tbl[6]  = '{I_R | I_DQ | I_EXR, C_DW};
    tbl[7]  = '{I_R | I_IDR, C_IDR};
    tbl[8]  = '{I_R | I_IQ, C_IW};
    tbl[9]  = '{I_R | I_IQ | I_IY, C_NORM};
    tbl[10] = '{I_R | I_IDR | I_IQ, C_IDR};
    tbl[11] = '{I_R | I_HZ | I_IQ, C_HZ};
    tbl[12] = '{I_R | I_IH | I_IV | I_HZ, C_HZ};
    tbl[13] = '{I_R | I_IH, C_NORM};
    tbl[14] = '{I_R | I_DQ | I_HZ, C_DW};

    apply(12'h000, C_RST);
    apply(12'h000, C_RST);
    apply(I_R, C_NORM);
    chk("reset halted", int'(halted), 0);
    chk("reset num_inst", int'(num_inst), 0);
    chk("reset stall_cycles", int'(stall_cycles), 0);

    foreach (tbl[i]) apply(tbl[i].in, tbl[i].ctrl);
    apply(I_R, C_NORM);
    chk("table stall_cycles", int'(stall_cycles), 3);
    chk("table halted", int'(halted), 0);
    apply(12'h000, C_RST);
    apply(I_R, C_NORM);
    chk("mid reset stall_cycles", int'(stall_cycles), 0);

    apply(I_R | I_HZ, C_HZ);
    apply(I_R | I_HZ, C_HZ);
    apply(I_R, C_NORM);
    chk("hazard stall_cycles", int'(stall_cycles), 2);
    apply(I_R | I_EXR | I_HZ, C_EXR);
    apply(I_R, C_NORM);
    chk("mispredict stall_cycles", int'(stall_cycles), 2);

    repeat (3) apply(I_R | I_DQ, C_DW);
    apply(I_R | I_DQ | I_DY, C_NORM);

    apply(I_R | I_IH | I_IV, C_NORM);
    repeat (3) apply(I_R, C_DRN);
    chk("drain halted", int'(halted), 0);
    apply(I_R | I_WV | I_WH, C_DRN);
    apply(I_R, C_HLT);
    chk("halted level", int'(halted), 1);
    chk("halt num_inst", int'(num_inst), 1);
    apply(I_R | I_WV, C_HLT);
    apply(I_R | I_HZ | I_EXR, C_HLT);
    apply(I_R, C_HLT);
    chk("halted num_inst frozen", int'(num_inst), 1);
    chk("halted stall frozen", int'(stall_cycles), 2);
    chk("halted sticky", int'(halted), 1);

    apply(12'h000, C_RST);
    apply(I_R, C_NORM);
    chk("unhalt by reset", int'(halted), 0);
    apply(I_R | I_IH | I_IV, C_NORM);
    apply(I_R, C_DRN);
    apply(I_R | I_EXR, C_EXR);
    apply(I_R, C_NORM);
    chk("wrong-path halted", int'(halted), 0);

    apply(12'h000, C_RST);
    repeat (17) apply(I_R | I_WV, C_NORM);
    apply(I_R, C_NORM);
    chk("num_inst wrap", int'(num_inst), 1);
    repeat (20) apply(I_R | I_HZ, C_HZ);
    apply(I_R, C_NORM);
    chk("stall saturate", int'(stall_cycles), 15);
    apply(12'h000, C_RST);
    apply(I_R, C_NORM);
    chk("final reset num_inst", int'(num_inst), 0);
    chk("final reset stall_cycles", int'(stall_cycles), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
